// File: rtl/sorter_pkg.sv
// Shared definitions for the weight sequencer: bus width, group thresholds and FSM states.
// Group classification is used only when WEIGHT_SEQUENCER_GROUP_TALLY_EN is defined.
package sorter_pkg;

    localparam int unsigned WEIGHT_W = 12;

    localparam logic [WEIGHT_W-1:0] GROUP1_MAX = 12'd250;
    localparam logic [WEIGHT_W-1:0] GROUP2_MAX = 12'd500;
    localparam logic [WEIGHT_W-1:0] GROUP3_MAX = 12'd750;
    localparam logic [WEIGHT_W-1:0] GROUP4_MAX = 12'd1500;
    localparam logic [WEIGHT_W-1:0] GROUP5_MAX = 12'd2000;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HOLD = 2'd1,
        ST_GAP  = 2'd2
    } seq_state_e;

    // Returns the group number 1..6 for a presented weight.
    function automatic logic [2:0] group_of(input logic [WEIGHT_W-1:0] w);
        if (w <= GROUP1_MAX)      return 3'd1;
        else if (w <= GROUP2_MAX) return 3'd2;
        else if (w <= GROUP3_MAX) return 3'd3;
        else if (w <= GROUP4_MAX) return 3'd4;
        else if (w <= GROUP5_MAX) return 3'd5;
        else                      return 3'd6;
    endfunction

endpackage

// File: rtl/weight_fifo.sv
// Synchronous FIFO of package weights; push is refused when full even if a pop
// happens in the same cycle, and a freshly pushed entry is visible one cycle later.
module weight_fifo #(
    parameter int unsigned WIDTH = 12,
    parameter int unsigned DEPTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/weight_sequencer.sv
// Presents queued package weights on a registered scale bus: HOLD_CYCLES of weight, then GAP_CYCLES of zero.
// Optional per-group tallies are enabled by defining WEIGHT_SEQUENCER_GROUP_TALLY_EN.
module weight_sequencer
    import sorter_pkg::*;
#(
    parameter int unsigned HOLD_CYCLES = 4,
    parameter int unsigned GAP_CYCLES  = 2,
    parameter int unsigned DEPTH       = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    input  logic [WEIGHT_W-1:0] in_weight,
    output logic                in_ready,
    output logic [WEIGHT_W-1:0] weight,
    output logic                busy,
    output logic [7:0]          sent_count,
    output logic                err_zero
`ifdef WEIGHT_SEQUENCER_GROUP_TALLY_EN
    ,
    output logic [7:0]          tally1,
    output logic [7:0]          tally2,
    output logic [7:0]          tally3,
    output logic [7:0]          tally4,
    output logic [7:0]          tally5,
    output logic [7:0]          tally6
`endif
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD  = 8'(GAP_CYCLES - 1);

    seq_state_e          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic                ready_en;
    logic                accept;
    logic                pop;
    logic                enter_gap;
    logic                fifo_full;
    logic                fifo_empty;
    logic [WEIGHT_W-1:0] head;

    assign in_ready = ready_en && !fifo_full;
    assign accept   = in_valid && in_ready;
    assign busy     = (state_q != ST_IDLE) || !fifo_empty;

    weight_fifo #(
        .WIDTH(WEIGHT_W),
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (accept && (in_weight != '0)),
        .push_data (in_weight),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pop       = 1'b0;
        enter_gap = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop     = 1'b1;
                    state_d = ST_HOLD;
                    cnt_d   = HOLD_LOAD;
                end
            end
            ST_HOLD: begin
                if (cnt_q == '0) begin
                    enter_gap = 1'b1;
                    state_d   = ST_GAP;
                    cnt_d     = GAP_LOAD;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_GAP: begin
                if (cnt_q == '0) begin
                    if (!fifo_empty) begin
                        pop     = 1'b1;
                        state_d = ST_HOLD;
                        cnt_d   = HOLD_LOAD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // in_ready stays low through reset and rises on the first edge after release.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ready_en   <= 1'b0;
            weight     <= '0;
            sent_count <= '0;
            err_zero   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ready_en <= 1'b1;
            err_zero <= accept && (in_weight == '0);
            if (pop)            weight <= head;
            else if (enter_gap) weight <= '0;
            if (enter_gap)      sent_count <= sent_count + 8'd1;
        end
    end

`ifdef WEIGHT_SEQUENCER_GROUP_TALLY_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tally1 <= '0;
            tally2 <= '0;
            tally3 <= '0;
            tally4 <= '0;
            tally5 <= '0;
            tally6 <= '0;
        end else if (enter_gap) begin
            case (group_of(weight))
                3'd1:    tally1 <= tally1 + 8'd1;
                3'd2:    tally2 <= tally2 + 8'd1;
                3'd3:    tally3 <= tally3 + 8'd1;
                3'd4:    tally4 <= tally4 + 8'd1;
                3'd5:    tally5 <= tally5 + 8'd1;
                default: tally6 <= tally6 + 8'd1;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_weight_sequencer.sv
// Bench for weight_sequencer: each accepted package gets a start edge computed from the
// HOLD/GAP schedule, and every cycle's outputs are derived from that schedule.
module tb_weight_sequencer;

    localparam int H = 4;
    localparam int G = 2;
    localparam int D = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic [11:0] in_weight = '0;
    logic        in_ready;
    logic [11:0] weight;
    logic        busy;
    logic [7:0]  sent_count;
    logic        err_zero;
`ifdef WEIGHT_SEQUENCER_GROUP_TALLY_EN
    logic [7:0]  tally1, tally2, tally3, tally4, tally5, tally6;
`endif

    weight_sequencer #(
        .HOLD_CYCLES(H),
        .GAP_CYCLES (G),
        .DEPTH      (D)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_weight  (in_weight),
        .in_ready   (in_ready),
        .weight     (weight),
        .busy       (busy),
        .sent_count (sent_count),
        .err_zero   (err_zero)
`ifdef WEIGHT_SEQUENCER_GROUP_TALLY_EN
        ,
        .tally1     (tally1),
        .tally2     (tally2),
        .tally3     (tally3),
        .tally4     (tally4),
        .tally5     (tally5),
        .tally6     (tally6)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int w;
        int tp;
        int s;
    } pkg_t;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    pkg_t sched[$];
    int   done;
    int   last_end;
    int   tally_m[1:6];
    bit   rdy_en;
    bit   exp_ready;
    bit   exp_err;
    bit   last_acc;
    int   cur_exp_w;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic int group_of_w(input int w);
        if (w <= 250)       return 1;
        else if (w <= 500)  return 2;
        else if (w <= 750)  return 3;
        else if (w <= 1500) return 4;
        else if (w <= 2000) return 5;
        else                return 6;
    endfunction

    task automatic model_clear();
        sched.delete();
        done      = 0;
        last_end  = 0;
        rdy_en    = 1'b0;
        exp_ready = 1'b0;
        exp_err   = 1'b0;
        cur_exp_w = 0;
        for (int g = 1; g <= 6; g++) tally_m[g] = 0;
    endtask

    task automatic check_outputs();
        check("weight", 32'(weight), 32'(cur_exp_w));
        check("sent_count", 32'(sent_count), 32'(done % 256));
        check("err_zero", 32'(err_zero), 32'(exp_err));
        check("busy", 32'(busy), 32'(sched.size() > 0));
`ifdef WEIGHT_SEQUENCER_GROUP_TALLY_EN
        check("tally1", 32'(tally1), 32'(tally_m[1] % 256));
        check("tally2", 32'(tally2), 32'(tally_m[2] % 256));
        check("tally3", 32'(tally3), 32'(tally_m[3] % 256));
        check("tally4", 32'(tally4), 32'(tally_m[4] % 256));
        check("tally5", 32'(tally5), 32'(tally_m[5] % 256));
        check("tally6", 32'(tally6), 32'(tally_m[6] % 256));
`endif
    endtask

    // One clock edge: check ready before it, advance the schedule, check outputs after it.
    task automatic step();
        bit acc;
        int w;
        int occ;
        int ew;
        @(negedge clk);
        check("in_ready", 32'(in_ready), 32'(exp_ready));
        acc = in_valid && exp_ready && reset;
        w   = int'(in_weight);
        @(posedge clk);
        cyc++;
        last_acc = acc;
        if (!reset) begin
            model_clear();
        end else begin
            exp_err = acc && (w == 0);
            if (acc && w != 0) begin
                int s;
                s = (cyc + 1 > last_end) ? cyc + 1 : last_end;
                sched.push_back('{w: w, tp: cyc, s: s});
                last_end = s + H + G;
            end
            foreach (sched[i]) begin
                if (sched[i].s + H == cyc) begin
                    done++;
                    tally_m[group_of_w(sched[i].w)]++;
                end
            end
            while (sched.size() > 0 && cyc >= sched[0].s + H + G) void'(sched.pop_front());
            rdy_en = 1'b1;
        end
        occ = 0;
        ew  = 0;
        foreach (sched[i]) begin
            if (sched[i].s > cyc) occ++;
            if (sched[i].s <= cyc && cyc < sched[i].s + H) ew = sched[i].w;
        end
        exp_ready = rdy_en && (occ < D);
        cur_exp_w = ew;
        #1;
        check_outputs();
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic send(input int w);
        in_valid  = 1'b1;
        in_weight = 12'(w);
        for (int k = 0; k < 500; k++) begin
            step();
            if (last_acc) break;
        end
        in_valid = 1'b0;
        check("send_accepted", 32'(last_acc), 32'd1);
    endtask

    task automatic async_reset(input int hold);
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        model_clear();
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check_outputs();
        for (int k = 0; k < hold; k++) step();
        reset = 1'b1;
    endtask

    initial begin
        int n;
        int dens;
        model_clear();
        last_acc = 1'b0;
        for (int k = 0; k < 3; k++) step();
        reset = 1'b1;
        idle(2);

        // single package: 4 cycles of weight then 2 of zero, back to idle
        send(100);
        idle(12);
        check("single_sent", 32'(sent_count), 32'd1);

        // back-to-back packages chain through GAP without an IDLE cycle
        send(300);
        send(800);
        send(2500);
        idle(25);
        check("chain_sent", 32'(sent_count), 32'd4);

        // zero weight is refused with an error pulse
        send(0);
        send(250);
        idle(12);

        // fill past DEPTH while the FSM is busy
        for (int k = 0; k < 9; k++) send(1000 + k * 100);
        idle(80);

        // reset in the second HOLD cycle of 1600 with three entries queued
        send(50);
        send(1600);
        send(500);
        send(600);
        send(700);
        n = 0;
        for (int k = 0; k < 200 && n < 2; k++) begin
            step();
            if (cur_exp_w == 1600) n++;
        end
        check("reach_hold_1600", 32'(n), 32'd2);
        async_reset(2);
        idle(20);
        check("post_reset_sent", 32'(sent_count), 32'd0);

        // 256 packages wrap sent_count and the group-1 tally
        for (int k = 0; k < 256; k++) send(100 + (k % 50));
        idle(20);
        check("wrap_sent_count", 32'(sent_count), 32'(done % 256));

        // randomized traffic with varying offer density
        async_reset(1);
        dens = 50;
        in_valid = 1'b0;
        last_acc = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (c % 300 == 0) dens = int'($urandom_range(10, 90));
            if (!in_valid || last_acc) begin
                in_valid  = ($urandom_range(0, 99) < dens);
                in_weight = ($urandom_range(0, 9) == 0) ? 12'd0 : 12'($urandom_range(1, 4095));
            end
            step();
        end
        idle(80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
